// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, immediate select and load-use bubble insertion.
// Flush beats hold beats load-use beats normal capture on each rising clk.
module id_ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int ALU_CW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_alu_src,
  input  logic [ALU_CW-1:0] id_alu_ctr,
  input  logic              id_mem_rd,
  input  logic              id_mem_wr,
  input  logic              id_reg_wr,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_reg_wr,
  input  logic [XLEN-1:0]   exm_result,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic              mwb_reg_wr,
  input  logic [XLEN-1:0]   mwb_result,
  output logic              stall_o,
  output logic              ex_valid,
  output logic [ALU_CW-1:0] alu_ctr,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [XLEN-1:0]   store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_mem_rd,
  output logic              ex_mem_wr,
  output logic              ex_reg_wr
);

  logic              r_valid;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic              r_alu_src;
  logic [ALU_CW-1:0] r_alu_ctr;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic              r_reg_wr;

  logic              w_load_use;
  logic              w_rs2_used;
  logic              w_exm_a;
  logic              w_exm_b;
  logic              w_mwb_a;
  logic              w_mwb_b;
  logic [XLEN-1:0]   w_fwd_a;
  logic [XLEN-1:0]   w_fwd_b;

  // rs2 matters for the hazard when it feeds operand B or is the store data
  assign w_rs2_used = !id_alu_src || id_mem_wr;
  assign w_load_use = r_valid && r_mem_rd && (r_rd != '0) && id_valid &&
                      ((id_rs1 == r_rd) || ((id_rs2 == r_rd) && w_rs2_used));
  assign stall_o    = w_load_use || hold_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_alu_src  <= 1'b0;
      r_alu_ctr  <= '0;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_reg_wr   <= 1'b0;
    end else if (flush_i || (!hold_i && w_load_use)) begin
      r_valid  <= 1'b0;
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
      r_reg_wr <= 1'b0;
      r_rd     <= '0;
    end else if (!hold_i) begin
      r_valid    <= id_valid;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rd       <= id_rd;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_alu_src  <= id_alu_src;
      r_alu_ctr  <= id_alu_ctr;
      r_mem_rd   <= id_valid && id_mem_rd;
      r_mem_wr   <= id_valid && id_mem_wr;
      r_reg_wr   <= id_valid && id_reg_wr;
    end
  end

  // Youngest producer wins; x0 is never forwarded
  assign w_exm_a = exm_reg_wr && (exm_rd != '0) && (exm_rd == r_rs1);
  assign w_exm_b = exm_reg_wr && (exm_rd != '0) && (exm_rd == r_rs2);
  assign w_mwb_a = mwb_reg_wr && (mwb_rd != '0) && (mwb_rd == r_rs1);
  assign w_mwb_b = mwb_reg_wr && (mwb_rd != '0) && (mwb_rd == r_rs2);

  assign w_fwd_a = w_exm_a ? exm_result : (w_mwb_a ? mwb_result : r_rs1_data);
  assign w_fwd_b = w_exm_b ? exm_result : (w_mwb_b ? mwb_result : r_rs2_data);

  assign ex_valid   = r_valid;
  assign alu_ctr    = r_alu_ctr;
  assign alu_a      = w_fwd_a;
  assign alu_b      = r_alu_src ? r_imm : w_fwd_b;
  assign store_data = w_fwd_b;
  assign ex_rd      = r_rd;
  assign ex_mem_rd  = r_mem_rd;
  assign ex_mem_wr  = r_mem_wr;
  assign ex_reg_wr  = r_reg_wr;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, capture, forwarding, load-use, flush/hold.
module tb_id_ex_operand_stage;
  localparam logic [3:0] ADD = 4'h1;
  localparam logic [3:0] SUB = 4'h2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_alu_src, id_mem_rd, id_mem_wr, id_reg_wr;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [3:0]  id_alu_ctr;
  logic        flush_i, hold_i;
  logic [4:0]  exm_rd, mwb_rd;
  logic        exm_reg_wr, mwb_reg_wr;
  logic [31:0] exm_result, mwb_result;
  logic        stall_o, ex_valid, ex_mem_rd, ex_mem_wr, ex_reg_wr;
  logic [3:0]  alu_ctr;
  logic [31:0] alu_a, alu_b, store_data;
  logic [4:0]  ex_rd;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_alu_ctr(id_alu_ctr), .id_mem_rd(id_mem_rd),
    .id_mem_wr(id_mem_wr), .id_reg_wr(id_reg_wr), .flush_i(flush_i), .hold_i(hold_i),
    .exm_rd(exm_rd), .exm_reg_wr(exm_reg_wr), .exm_result(exm_result),
    .mwb_rd(mwb_rd), .mwb_reg_wr(mwb_reg_wr), .mwb_result(mwb_result),
    .stall_o(stall_o), .ex_valid(ex_valid), .alu_ctr(alu_ctr), .alu_a(alu_a), .alu_b(alu_b),
    .store_data(store_data), .ex_rd(ex_rd), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_reg_wr(ex_reg_wr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic src, input logic [3:0] ctr,
                        input logic mrd, input logic mwr, input logic rwr);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_src = src;
    id_alu_ctr = ctr; id_mem_rd = mrd; id_mem_wr = mwr; id_reg_wr = rwr;
  endtask

  task automatic fwd_off();
    exm_rd = 5'd0; exm_reg_wr = 1'b0; exm_result = 32'h0;
    mwb_rd = 5'd0; mwb_reg_wr = 1'b0; mwb_result = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    fwd_off();
    #1;
    chk("reset_valid", 32'(ex_valid), 32'd0);
    chk("reset_reg_wr", 32'(ex_reg_wr), 32'd0);
    chk("reset_alu_a", alu_a, 32'h0);
    chk("reset_alu_b", alu_b, 32'h0);
    chk("reset_stall", 32'(stall_o), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // ADD x3,x1,x2 with x1=5, x2=7
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 1'b0, ADD, 1'b0, 1'b0, 1'b1);
    step();
    chk("add_alu_a", alu_a, 32'd5);
    chk("add_alu_b", alu_b, 32'd7);
    chk("add_ctr", 32'(alu_ctr), 32'(ADD));
    chk("add_rd", 32'(ex_rd), 32'd3);
    chk("add_valid", 32'(ex_valid), 32'd1);
    chk("add_reg_wr", 32'(ex_reg_wr), 32'd1);

    // Forward priority on the captured ADD
    exm_rd = 5'd1; exm_reg_wr = 1'b1; exm_result = 32'hAA;
    mwb_rd = 5'd1; mwb_reg_wr = 1'b1; mwb_result = 32'hBB;
    #1 chk("fwd_exm_beats_mwb", alu_a, 32'hAA);
    exm_rd = 5'd0;
    #1 chk("fwd_x0_falls_to_mwb", alu_a, 32'hBB);
    exm_rd = 5'd2;
    #1 chk("fwd_b_from_exm", alu_b, 32'hAA);
    chk("fwd_a_mwb_when_exm_b", alu_a, 32'hBB);
    mwb_reg_wr = 1'b0;
    #1 chk("fwd_mwb_no_wr", alu_a, 32'd5);
    fwd_off();

    // ADDI: operand B from the immediate, store_data still follows rs2
    set_id(1'b1, 5'd1, 5'd2, 5'd6, 32'd5, 32'd7, 32'h100, 1'b1, ADD, 1'b0, 1'b0, 1'b1);
    step();
    chk("imm_alu_b", alu_b, 32'h100);
    chk("imm_store_data", store_data, 32'd7);
    exm_rd = 5'd2; exm_reg_wr = 1'b1; exm_result = 32'h55;
    #1 chk("imm_store_fwd", store_data, 32'h55);
    chk("imm_alu_b_unfwd", alu_b, 32'h100);
    exm_reg_wr = 1'b0;
    #1 chk("store_no_fwd_without_wr", store_data, 32'd7);
    fwd_off();

    // Invalid instruction: controls forced to zero
    set_id(1'b0, 5'd1, 5'd2, 5'd9, 32'd1, 32'd2, 32'h0, 1'b0, ADD, 1'b1, 1'b1, 1'b1);
    step();
    chk("inv_valid", 32'(ex_valid), 32'd0);
    chk("inv_reg_wr", 32'(ex_reg_wr), 32'd0);
    chk("inv_mem_wr", 32'(ex_mem_wr), 32'd0);
    chk("inv_mem_rd", 32'(ex_mem_rd), 32'd0);

    // LW x4 then ADD x5,x4,x4
    set_id(1'b1, 5'd1, 5'd0, 5'd4, 32'd0, 32'd0, 32'h8, 1'b1, ADD, 1'b1, 1'b0, 1'b1);
    step();
    chk("lw_mem_rd", 32'(ex_mem_rd), 32'd1);
    set_id(1'b1, 5'd4, 5'd4, 5'd5, 32'h11, 32'h11, 32'h0, 1'b0, ADD, 1'b0, 1'b0, 1'b1);
    #1 chk("lu_stall", 32'(stall_o), 32'd1);
    step();
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_bubble_reg_wr", 32'(ex_reg_wr), 32'd0);
    chk("lu_stall_released", 32'(stall_o), 32'd0);
    mwb_rd = 5'd4; mwb_reg_wr = 1'b1; mwb_result = 32'h1234;
    step();
    chk("lu_add_valid", 32'(ex_valid), 32'd1);
    chk("lu_add_rd", 32'(ex_rd), 32'd5);
    chk("lu_add_a_fwd", alu_a, 32'h1234);
    chk("lu_add_b_fwd", alu_b, 32'h1234);
    fwd_off();

    // Store rs2 hazard despite alu_src=1; ADDI with same rs2 does not stall
    set_id(1'b1, 5'd1, 5'd0, 5'd4, 32'd0, 32'd0, 32'h8, 1'b1, ADD, 1'b1, 1'b0, 1'b1);
    step();
    set_id(1'b1, 5'd9, 5'd4, 5'd0, 32'h0, 32'h0, 32'h4, 1'b1, ADD, 1'b0, 1'b1, 1'b0);
    #1 chk("lu_store_rs2", 32'(stall_o), 32'd1);
    set_id(1'b1, 5'd9, 5'd4, 5'd7, 32'h0, 32'h0, 32'h4, 1'b1, ADD, 1'b0, 1'b0, 1'b1);
    #1 chk("lu_imm_rs2_ignored", 32'(stall_o), 32'd0);

    // Load into x0 never stalls
    set_id(1'b1, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 32'h8, 1'b1, ADD, 1'b1, 1'b0, 1'b1);
    step();
    set_id(1'b1, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, 1'b0, ADD, 1'b0, 1'b0, 1'b1);
    #1 chk("lu_x0_no_stall", 32'(stall_o), 32'd0);

    // SW in EX, then flush and hold on the same edge
    set_id(1'b1, 5'd1, 5'd2, 5'd0, 32'd1, 32'd2, 32'h0, 1'b1, ADD, 1'b0, 1'b1, 1'b0);
    step();
    chk("sw_mem_wr", 32'(ex_mem_wr), 32'd1);
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'h0, 1'b0, ADD, 1'b0, 1'b1, 1'b1);
    flush_i = 1'b1; hold_i = 1'b1;
    step();
    chk("flush_hold_valid", 32'(ex_valid), 32'd0);
    chk("flush_hold_reg_wr", 32'(ex_reg_wr), 32'd0);
    chk("flush_hold_mem_wr", 32'(ex_mem_wr), 32'd0);
    flush_i = 1'b0; hold_i = 1'b0;

    // Hold for three cycles while decode keeps changing
    set_id(1'b1, 5'd1, 5'd2, 5'd7, 32'h21, 32'h22, 32'h0, 1'b0, SUB, 1'b0, 1'b0, 1'b1);
    step();
    hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'd3, 5'd4, 5'(8 + i), 32'(32'h40 + i), 32'h50, 32'h0, 1'b0, ADD, 1'b0, 1'b0, 1'b1);
      #1 chk("hold_stall", 32'(stall_o), 32'd1);
      step();
      chk("hold_rd", 32'(ex_rd), 32'd7);
      chk("hold_alu_a", alu_a, 32'h21);
      chk("hold_ctr", 32'(alu_ctr), 32'(SUB));
    end
    hold_i = 1'b0;
    set_id(1'b1, 5'd3, 5'd4, 5'd9, 32'h99, 32'h98, 32'h0, 1'b0, ADD, 1'b0, 1'b0, 1'b1);
    step();
    chk("resume_rd", 32'(ex_rd), 32'd9);
    chk("resume_alu_a", alu_a, 32'h99);

    // Asynchronous reset mid-stream, away from any edge
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ex_valid), 32'd0);
    chk("mid_rst_reg_wr", 32'(ex_reg_wr), 32'd0);
    chk("mid_rst_rd", 32'(ex_rd), 32'd0);
    chk("mid_rst_alu_a", alu_a, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
